// File: rtl/seg7_scan_driver.sv
// Six-digit common-anode 7-segment scan driver.
// Frame-latched digits, anode guard band, leading-zero blanking.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec0,
    input  logic [3:0] sec1,
    input  logic [3:0] min0,
    input  logic [3:0] min1,
    input  logic [3:0] hrs0,
    input  logic [3:0] hrs1,
    input  logic       dp_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'd5;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          tick;
    logic          frame_end;

    logic [3:0] snap_s0;
    logic [3:0] snap_s1;
    logic [3:0] snap_m0;
    logic [3:0] snap_m1;
    logic [3:0] snap_h0;
    logic [3:0] snap_h1;
    logic       snap_dp;

    logic [3:0] digit;
    logic       guard;
    logic       lz_h1;
    logic       lz_h0;
    logic       lz_m1;
    logic       slot_blank;
    logic       slot_valid;
    logic       an_on;
    logic       dp_slot;
    logic [5:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    // Active-high {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Slot-end strobe and the last slot of a frame.
    always_comb begin
        tick      = (cnt == CNT_LAST);
        frame_end = tick && (idx == IDX_LAST);
    end

    // Prescaler and slot index advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Latch all digits together at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_s0 <= '0;
            snap_s1 <= '0;
            snap_m0 <= '0;
            snap_m1 <= '0;
            snap_h0 <= '0;
            snap_h1 <= '0;
            snap_dp <= 1'b0;
        end else if (frame_end) begin
            snap_s0 <= sec0;
            snap_s1 <= sec1;
            snap_m0 <= min0;
            snap_m1 <= min1;
            snap_h0 <= hrs0;
            snap_h1 <= hrs1;
            snap_dp <= dp_en;
        end
    end

    // Select the latched digit for the current slot.
    always_comb begin
        digit = 4'd0;
        case (idx)
            3'd0:    digit = snap_s0;
            3'd1:    digit = snap_s1;
            3'd2:    digit = snap_m0;
            3'd3:    digit = snap_m1;
            3'd4:    digit = snap_h0;
            3'd5:    digit = snap_h1;
            default: digit = 4'd0;
        endcase
    end

    // Leading-zero chain runs from the hours tens digit downward.
    always_comb begin
        lz_h1 = BLANK_LZ && (snap_h1 == 4'd0);
        lz_h0 = lz_h1 && (snap_h0 == 4'd0);
        lz_m1 = lz_h0 && (snap_m1 == 4'd0);
        slot_blank = 1'b0;
        case (idx)
            3'd3:    slot_blank = lz_m1;
            3'd4:    slot_blank = lz_h0;
            3'd5:    slot_blank = lz_h1;
            default: slot_blank = 1'b0;
        endcase
    end

    // Next anode/segment/dp values from the current scan state.
    always_comb begin
        guard      = (32'(cnt) < BLANK_CYCLES);
        slot_valid = (idx <= IDX_LAST);
        an_on      = slot_valid && !guard && !slot_blank;
        dp_slot    = (idx == 3'd2) || (idx == 3'd4);
        an_nxt     = 6'h3F;
        if (an_on) begin
            an_nxt = ~(6'd1 << idx);
        end
        seg_nxt = ~decode(digit);
        dp_nxt  = ~(snap_dp && dp_slot && an_on);
    end

    // Registered display outputs, all dark in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 6'h3F;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule
